// File: rtl/goertzel_pkg.sv
// Shared Q2.14 constants, FSM encodings and the elaboration-time quarter-sine generator
// for the Goertzel trig-coefficient path.
package goertzel_pkg;

  localparam int FRAC_BITS = 14;
  localparam int ONE       = 1 << FRAC_BITS;

  typedef enum logic [2:0] {IDLE, RD_SIN, RD_COS, CAP_COS, PRESENT} state_t;

  function automatic int qtr_depth(input int num_samples);
    return num_samples / 4 + 1;
  endfunction

  // Integer Taylor series in 2^30 fixed point so the table needs no real math at elaboration.
  localparam longint FX_ONE     = 64'sd1073741824;
  localparam longint HALF_PI_FX = 64'sd1686629713;

  function automatic int sine_q14(input int i, input int q, input int amp);
    longint x, x2, term, acc;
    x    = (HALF_PI_FX * longint'(i)) / longint'(q);
    x2   = (x * x) / FX_ONE;
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -(term * x2) / FX_ONE / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return int'((acc * longint'(amp) + FX_ONE / 2) / FX_ONE);
  endfunction

endpackage

// File: rtl/goertzel_trig_server_if.sv
// Manager/register-block side of the trig server: request pulse, (sin, cos) result and bin plan.
// No backpressure: the master must accept trig_ready whenever it pulses.
interface goertzel_trig_server_if #(
  parameter int NS_BITS = 9
);
  logic                      request_trig;
  logic                      trig_ready;
  logic signed [15:0]        sin_out;
  logic signed [15:0]        cos_out;
  logic [NS_BITS-1:0]        bin_idx;
  logic                      frame_done;
  logic [NS_BITS-1:0]        base_bin;
  logic [NS_BITS-1:0]        bin_step;
  logic [5:0]                bins_per_frame;
  logic                      seq_restart;

  modport master (
    output request_trig, base_bin, bin_step, bins_per_frame, seq_restart,
    input  trig_ready, sin_out, cos_out, bin_idx, frame_done
  );

  modport slave (
    input  request_trig, base_bin, bin_step, bins_per_frame, seq_restart,
    output trig_ready, sin_out, cos_out, bin_idx, frame_done
  );
endinterface

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table, Q+1 unsigned Q2.14 entries; one-cycle registered read.
// No backpressure; data output is not reset.
module quarter_sine_rom
  import goertzel_pkg::*;
#(
  parameter int NUM_SAMPLES = 512,
  parameter int AMP         = ONE,
  parameter int AW          = 8
) (
  input  logic          sys_clk,
  input  logic [AW-1:0] addr,
  output logic [15:0]   rd_dat
);
  localparam int DEPTH = qtr_depth(NUM_SAMPLES);

  logic [15:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [15:0] VAL = 16'(sine_q14(g, NUM_SAMPLES / 4, AMP));
    assign rom[g] = VAL;
  end

  always_ff @(posedge sys_clk) begin
    rd_dat <= rom[addr];
  end
endmodule

// File: rtl/goertzel_trig_server.sv
// Serves one signed Q2.14 (sin, cos) pair per request edge; trig_ready 4 cycles after the edge.
// No backpressure; one extra edge is queued while busy, further edges are dropped.
module goertzel_trig_server
  import goertzel_pkg::*;
#(
  parameter int NUM_SAMPLES = 512,
  parameter int NS_BITS     = 9,
  parameter int AMP         = ONE
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  goertzel_trig_server_if.slave bus
);
  localparam int Q  = NUM_SAMPLES / 4;
  localparam int AW = NS_BITS - 1;

  state_t              state, state_nxt;
  logic                req_q, req_pend, rst_pend, req_edge, frame_end;
  logic [NS_BITS-1:0]  k, p_cos;
  logic [5:0]          served;
  logic signed [15:0]  sin_q, cos_q;
  logic [AW-1:0]       rom_addr;
  logic [15:0]         rom_dat;

  // Odd quadrants read the table mirrored; the upper quadrant bit selects the sign.
  function automatic logic [AW-1:0] qaddr(input logic [NS_BITS-1:0] p);
    logic [AW-1:0] off;
    off = AW'(p[NS_BITS-3:0]);
    return p[NS_BITS-2] ? AW'(Q) - off : off;
  endfunction

  function automatic logic signed [15:0] apply_sign(input logic neg, input logic [15:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  assign req_edge  = bus.request_trig && !req_q;
  assign p_cos     = k + NS_BITS'(Q);
  assign frame_end = (bus.bins_per_frame != 6'd0) &&
                     (({1'b0, served} + 7'd1) == {1'b0, bus.bins_per_frame});

  quarter_sine_rom #(.NUM_SAMPLES(NUM_SAMPLES), .AMP(AMP), .AW(AW)) u_rom (
    .sys_clk (sys_clk),
    .addr    (rom_addr),
    .rd_dat  (rom_dat)
  );

  always_comb begin
    state_nxt = state;
    rom_addr  = qaddr(p_cos);
    case (state)
      IDLE:    if (req_edge || req_pend) state_nxt = RD_SIN;
      RD_SIN:  begin
        state_nxt = RD_COS;
        rom_addr  = qaddr(k);
      end
      RD_COS:  state_nxt = CAP_COS;
      CAP_COS: state_nxt = PRESENT;
      PRESENT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= IDLE;
      req_q          <= 1'b0;
      req_pend       <= 1'b0;
      rst_pend       <= 1'b0;
      k              <= '0;
      served         <= '0;
      sin_q          <= '0;
      cos_q          <= '0;
      bus.trig_ready <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.sin_out    <= '0;
      bus.cos_out    <= '0;
      bus.bin_idx    <= '0;
    end else begin
      state          <= state_nxt;
      req_q          <= bus.request_trig;
      bus.trig_ready <= 1'b0;
      bus.frame_done <= 1'b0;
      if (state == IDLE) begin
        req_pend <= 1'b0;
        if (bus.seq_restart) begin
          k      <= bus.base_bin;
          served <= '0;
        end
      end else begin
        if (req_edge)        req_pend <= 1'b1;
        if (bus.seq_restart) rst_pend <= 1'b1;
      end
      case (state)
        RD_COS:  sin_q <= apply_sign(k[NS_BITS-1], rom_dat);
        CAP_COS: cos_q <= apply_sign(p_cos[NS_BITS-1], rom_dat);
        PRESENT: begin
          bus.sin_out    <= sin_q;
          bus.cos_out    <= cos_q;
          bus.bin_idx    <= k;
          bus.trig_ready <= 1'b1;
          bus.frame_done <= frame_end;
          rst_pend       <= 1'b0;
          // A restart seen during this lookup overrides the normal advance.
          if (frame_end || rst_pend || bus.seq_restart) begin
            k      <= bus.base_bin;
            served <= '0;
          end else begin
            k      <= k + bus.bin_step;
            served <= served + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/goertzel_trig_server.md
Name: goertzel_trig_server

Overview:
- Responder end of the Goertzel trig-coefficient handshake. Each request from the Goertzel manager returns one (sin, cos) pair for the next bin in a programmable bin sequence.
- Values are Q2.14 signed, generated from a quarter-wave sine ROM using four-quadrant symmetry. The manager applies the cos*2 scaling itself.
- Sits between the control/UART register block (bin plan) and the dual Goertzel manager (request_trig / trig_ready / sin_in / cos_in).

Parameters:
- NUM_SAMPLES, 512, Goertzel block length N; bin phase is k mod N. Must be a power of two, >= 8.
- NS_BITS, 9, log2(NUM_SAMPLES); width of bin index and phase.
- AMP, 16384, full-scale ROM amplitude (1.0 in Q2.14).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- request_trig  in  1  coefficient request from manager; rising edge = one request
- trig_ready  out  1  one-cycle pulse; sin_out/cos_out valid in the same cycle
- sin_out  out  16  signed Q2.14 sin(2*pi*k/N)
- cos_out  out  16  signed Q2.14 cos(2*pi*k/N)
- base_bin  in  NS_BITS  first bin k of each frame
- bin_step  in  NS_BITS  bin increment per served request
- bins_per_frame  in  6  requests per frame before k reloads base_bin; 0 = free-run, never reload
- seq_restart  in  1  pulse: reload k <= base_bin, clear served count
- bin_idx  out  NS_BITS  bin k of the pair currently on sin_out/cos_out
- frame_done  out  1  one-cycle pulse coincident with trig_ready of the last pair in a frame

Behaviour:
- Reset (async, sys_rst high):
  - trig_ready=0, frame_done=0, sin_out=0, cos_out=0, bin_idx=0.
  - k=0, served count=0, pending flags cleared, req_q=0, state=IDLE.
  - Reset mid-operation abandons any in-flight lookup; no trig_ready pulse is produced for it.
- Request detection: req_q registers request_trig; an edge is request_trig && !req_q.
  - Level-held requests count once.
  - An edge arriving while not IDLE sets req_pend. It is serviced immediately after PRESENT; at most one is queued, further edges are dropped.
- Phase mapping (p = k[NS_BITS-1:0], Q = NUM_SAMPLES/4):
  - Quadrant = p[NS_BITS-1:NS_BITS-2]; off = p[NS_BITS-3:0].
  - ROM holds Q+1 entries: ROM[i] = round(AMP*sin(pi/2*i/Q)), with ROM[0]=0 and ROM[Q]=AMP.
  - Q0: +ROM[off]. Q1: +ROM[Q-off]. Q2: -ROM[off]. Q3: -ROM[Q-off].
  - Negation is two's complement in 16 bits; -AMP = 0xC000, and no saturation is needed.
  - cos uses phase p+Q (mod N).
- State machine (one synchronous-read ROM port, shared):
  - IDLE: on edge or req_pend -> RD_SIN. Clear req_pend if it is consumed.
  - RD_SIN: drive sin address -> RD_COS.
  - RD_COS: capture signed sin; drive cos address -> CAP_COS.
  - CAP_COS: capture signed cos -> PRESENT.
  - PRESENT: load sin_out/cos_out/bin_idx, pulse trig_ready, then advance k -> IDLE.
- Latency: edge sampled at clock edge E0 -> trig_ready high for exactly the one cycle following E4. Fixed; no backpressure.
- Output hold: sin_out, cos_out and bin_idx hold their values until the next PRESENT.
- Advance rule in PRESENT:
  - served+1 == bins_per_frame (nonzero): k <= base_bin, served <= 0, frame_done pulses with trig_ready.
  - Otherwise: k <= k + bin_step (wraps mod N), served <= served+1.
- seq_restart:
  - In IDLE: takes effect that cycle.
  - Otherwise: latched into rst_pend and applied after PRESENT, overriding the advance rule (no frame_done unless the frame genuinely ended).
  - Simultaneous seq_restart and request edge in IDLE: restart first; the request is served with k=base_bin.
- base_bin, bin_step and bins_per_frame are sampled only when used; changes mid-frame affect the next reload/advance only.

Decomposition:
- Shared package goertzel_pkg:
  - Q2.14 constants (FRAC_BITS=14, ONE=16384).
  - Quarter-table depth NUM_SAMPLES/4+1.
  - State encodings IDLE/RD_SIN/RD_COS/CAP_COS/PRESENT.
- Sub-module quarter_sine_rom:
  - Synchronous read, registered 16-bit unsigned output.
  - Contents generated at elaboration or from an init file; no reset on the data output.
- Quadrant/sign logic, sequencing and handshake stay in goertzel_trig_server.

Test Plan:
- Quadrant points, bins_per_frame=0, bin_step=128, base_bin=0, four requests:
  - pair 1: sin 0, cos 16384
  - pair 2: sin 16384, cos 0
  - pair 3: sin 0, cos -16384 (0xC000)
  - pair 4: sin -16384, cos 0
  - Each trig_ready arrives exactly 4 cycles after its request edge.
- Octant: base_bin=64 -> sin=cos=11585; base_bin=448 -> sin=-11585, cos=11585.
- Frame wrap: base_bin=20, bin_step=10, bins_per_frame=2, five requests -> bin_idx 20, 30, 20, 30, 20; frame_done on the 2nd and 4th pulses only.
- Index wrap: base_bin=500, bin_step=20, free-run -> bin_idx 500, 8, 28.
- Back-to-back edges: request pulsed at cycle 0 and cycle 2 -> two trig_ready pulses, the second 5 cycles after the first. A third edge while req_pend is set is dropped.
- Reset mid-lookup: sys_rst asserted in CAP_COS -> no trig_ready; all outputs 0. The next request returns the bin-0 pair (sin 0, cos 16384).
